// File: rtl/panel_pkg.sv
// Shared definitions for the 74LV165 front-panel scanner: FSM encoding and
// default geometry / timing parameters.
package panel_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] SHIFT  = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_LOAD   = LOAD,
    ST_SHIFT  = SHIFT,
    ST_UPDATE = UPDATE
  } state_e;

  localparam int PNL_CHAINS = 5;
  localparam int PNL_BITS   = 16;
  localparam int PNL_DIV    = 4;
  localparam int PNL_DEB    = 3;

endpackage

// File: rtl/panel_deb_cell.sv
// One panel bit: DEB-deep frame history, debounced level and edge pulses.
// The history is updated and judged on the same commit strobe.
module panel_deb_cell
  import panel_pkg::*;
#(
  parameter int DEB = PNL_DEB
) (
  input  logic clk,
  input  logic reset,
  input  logic commit,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [DEB-1:0] hist_q, hist_d;
  logic           level_q, level_d;
  logic           rise_q, rise_d;
  logic           fall_q, fall_d;

  // Push the new frame and change level only when every stored frame agrees.
  always_comb begin
    hist_d  = hist_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (commit) begin
      hist_d = (hist_q << 1'b1) | DEB'(raw);
      if ((&hist_d) && !level_q) begin
        level_d = 1'b1;
        rise_d  = 1'b1;
      end else if (!(|hist_d) && level_q) begin
        level_d = 1'b0;
        fall_d  = 1'b1;
      end else begin
        level_d = level_q;
      end
    end else begin
      hist_d = hist_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q  <= {DEB{1'b0}};
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/panel_scan_74lv165.sv
// Scans CHAINS parallel 74LV165 chains MSB first, then commits each frame
// into an array of debounce cells.
module panel_scan_74lv165
  import panel_pkg::*;
#(
  parameter int CHAINS = PNL_CHAINS,
  parameter int BITS   = PNL_BITS,
  parameter int DIV    = PNL_DIV,
  parameter int DEB    = PNL_DEB
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  output logic                     RCLK,
  output logic                     SH_LDn,
  input  logic [CHAINS-1:0]        QH,
  output logic [CHAINS*BITS-1:0]   level,
  output logic [CHAINS*BITS-1:0]   rise,
  output logic [CHAINS*BITS-1:0]   fall,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int NB    = CHAINS * BITS;
  localparam int CNT_W = $clog2(2 * DIV);
  localparam int BIT_W = $clog2(BITS + 1);
  localparam logic [CNT_W-1:0] LOW_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(2 * DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [BIT_W-1:0]             bit_q, bit_d;
  logic [CHAINS-1:0][BITS-1:0]  sreg_q, sreg_d;
  logic                         rclk_q, rclk_d;
  logic                         sh_ld_n_q, sh_ld_n_d;
  logic                         busy_q, busy_d;
  logic                         frame_done_q, frame_done_d;
  logic                         commit_s;
  logic [NB-1:0]                raw_s;

  // Next-state, counters and sampling; outputs derive from the next state so
  // that the registered pins line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_LOAD;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (cnt_q == LOW_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = {CNT_W{1'b0}};
          bit_d   = {BIT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        for (int c = 0; c < CHAINS; c++) begin
          if (cnt_q == LOW_LAST) begin
            sreg_d[c] = (sreg_q[c] << 1'b1) | BITS'(QH[c]);
          end else begin
            sreg_d[c] = sreg_q[c];
          end
        end
        if (cnt_q == PER_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (bit_q == BIT_LAST) begin
            state_d = ST_UPDATE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_UPDATE: begin
        cnt_d = {CNT_W{1'b0}};
        if (enable) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    sh_ld_n_d    = (state_d != ST_LOAD);
    rclk_d       = (state_d == ST_SHIFT) && (cnt_d > LOW_LAST);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_q == ST_UPDATE);
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      bit_q        <= {BIT_W{1'b0}};
      sreg_q       <= {NB{1'b0}};
      rclk_q       <= 1'b0;
      sh_ld_n_q    <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sreg_q       <= sreg_d;
      rclk_q       <= rclk_d;
      sh_ld_n_q    <= sh_ld_n_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign commit_s   = (state_q == ST_UPDATE);
  assign raw_s      = sreg_q;
  assign RCLK       = rclk_q;
  assign SH_LDn     = sh_ld_n_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  for (genvar i = 0; i < NB; i++) begin : g_cell
    panel_deb_cell #(.DEB(DEB)) u_cell (
      .clk    (clk),
      .reset  (reset),
      .commit (commit_s),
      .raw    (raw_s[i]),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

endmodule

// File: tb/tb_panel_scan_74lv165.sv
// Self-checking bench: 74LV165 chain models feed two scanner instances; a
// per-bit run-length debounce model predicts level / rise / fall per frame.
module tb_panel_scan_74lv165;

  localparam int DEB = 3;
  localparam int NF  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, enable_b;
  logic        rclk, sh_ld_n, frame_done, busy;
  logic [4:0]  qh;
  logic [79:0] level, rise, fall;
  logic        rclk_b, sh_ld_n_b, frame_done_b, busy_b;
  logic [0:0]  qh_b;
  logic [7:0]  level_b, rise_b, fall_b;

  panel_scan_74lv165 #(.CHAINS(5), .BITS(16), .DIV(4), .DEB(3)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .RCLK(rclk), .SH_LDn(sh_ld_n),
    .QH(qh), .level(level), .rise(rise), .fall(fall),
    .frame_done(frame_done), .busy(busy)
  );

  panel_scan_74lv165 #(.CHAINS(1), .BITS(8), .DIV(1), .DEB(1)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .RCLK(rclk_b), .SH_LDn(sh_ld_n_b),
    .QH(qh_b), .level(level_b), .rise(rise_b), .fall(fall_b),
    .frame_done(frame_done_b), .busy(busy_b)
  );

  // 74LV165 chain models: parallel load while SH_LDn low, shift toward QH on RCLK rise.
  logic [79:0]       panel;
  logic [4:0][15:0]  chain_q = '0;
  logic              rclk_prev = 1'b0;
  logic [7:0]        panel_b;
  logic [7:0]        chain_b_q = 8'd0;
  logic              rclk_b_prev = 1'b0;

  always @(negedge clk) begin
    if (!sh_ld_n) chain_q <= panel;
    else if (rclk && !rclk_prev) for (int c = 0; c < 5; c++) chain_q[c] <= chain_q[c] << 1;
    rclk_prev <= rclk;
    if (!sh_ld_n_b) chain_b_q <= panel_b;
    else if (rclk_b && !rclk_b_prev) chain_b_q <= chain_b_q << 1;
    rclk_b_prev <= rclk_b;
  end

  always_comb begin
    for (int c = 0; c < 5; c++) qh[c] = chain_q[c][15];
    qh_b[0] = chain_b_q[7];
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: per bit, track the value of the current run of identical frames
  // and its length; level adopts the run value once it has lasted DEB frames.
  logic [79:0] exp_level, exp_rise, exp_fall, run_val;
  int          run_len [80];

  task automatic model_reset();
    exp_level = '0; exp_rise = '0; exp_fall = '0; run_val = '0;
    for (int i = 0; i < 80; i++) run_len[i] = DEB;
  endtask

  task automatic model_commit(input logic [79:0] raw);
    exp_rise = '0; exp_fall = '0;
    for (int i = 0; i < 80; i++) begin
      if (raw[i] == run_val[i]) begin
        if (run_len[i] < DEB) run_len[i]++;
      end else begin
        run_val[i] = raw[i];
        run_len[i] = 1;
      end
      if (run_len[i] >= DEB && run_val[i] != exp_level[i]) begin
        exp_level[i] = run_val[i];
        if (run_val[i]) exp_rise[i] = 1'b1;
        else exp_fall[i] = 1'b1;
      end
    end
  endtask

  int last_fd;
  bit have_prev;

  // Wait for the next committed frame, check it, then present the next panel word.
  task automatic frame_a(input logic [79:0] next_panel,
                         output logic [79:0] lv, output logic [79:0] rs, output logic [79:0] fl);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk); #1;
      if (frame_done) got = 1'b1;
    end
    chk("frame_seen", got, 1'b1);
    lv = level; rs = rise; fl = fall;
    if (got) begin
      if (have_prev) chk("frame_len", cyc_cnt - last_fd, 133);
      last_fd = cyc_cnt;
      have_prev = 1'b1;
      model_commit(panel);
      chk("level", level, exp_level);
      chk("rise", rise, exp_rise);
      chk("fall", fall, exp_fall);
    end
    panel = next_panel;
    @(posedge clk); #1;
    chk("pulse_1cyc", {rise | fall, frame_done}, 81'd0);
  endtask

  logic [79:0] frames [NF];
  logic [79:0] base, w, lv, rs, fl;
  logic [7:0]  prev_b;
  int          k, act;
  bit          got_b;

  initial begin
    reset = 1'b1; enable = 1'b0; enable_b = 1'b0;
    panel = '0; panel_b = 8'd0;
    model_reset();
    have_prev = 1'b0; last_fd = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_level", level, 80'd0);
    chk("rst_pulses", rise | fall, 80'd0);
    chk("rst_ctl", {frame_done, busy, rclk, sh_ld_n}, 4'b0001);
    chk("rst_b", {level_b, rise_b, fall_b, frame_done_b, busy_b, rclk_b, sh_ld_n_b}, 28'd1);
    reset = 1'b0;

    base = 80'({$urandom(), $urandom(), $urandom()});
    base[15:0]  = 16'hA5C3;
    base[39]    = 1'b0;
    base[79:64] = 16'hFFFF;
    for (int i = 0; i < 3; i++) frames[i] = base;
    w = base; w[39] = 1'b1; w[79:64] = 16'h0000;
    frames[3] = w; frames[4] = w;
    w[39] = 1'b0;
    frames[5] = w; frames[6] = w;
    k = 7;
    while (k < NF) begin
      w = 80'({$urandom(), $urandom(), $urandom()});
      for (int h = $urandom_range(1, 3); h > 0 && k < NF; h--) begin
        frames[k] = w;
        k++;
      end
    end

    panel = frames[0];
    enable = 1'b1;
    for (int i = 0; i < NF; i++) begin
      frame_a((i + 1 < NF) ? frames[i + 1] : frames[NF - 1], lv, rs, fl);
      if (i == 2) begin
        chk("a5c3_level", lv[15:0], 16'hA5C3);
        chk("a5c3_rise", rs[15:0], 16'hA5C3);
      end
      if (i >= 3 && i <= 6) chk("glitch_bit39", {lv[39], rs[39], fl[39]}, 3'b000);
      if (i == 5) chk("chain4_fall", fl[79:64], 16'hFFFF);
    end

    // Abort part-way through a frame with a nonzero level.
    repeat (68) @(posedge clk);
    #1;
    chk("pre_reset_nz", level != 80'd0, 1'b1);
    reset = 1'b1;
    #1;
    chk("arst_level", level, 80'd0);
    chk("arst_pulses", rise | fall, 80'd0);
    chk("arst_ctl", {frame_done, busy, rclk, sh_ld_n}, 4'b0001);
    @(posedge clk); #1;
    model_reset();
    have_prev = 1'b0;
    panel = {80{1'b1}};
    reset = 1'b0;
    frame_a({80{1'b1}}, lv, rs, fl);
    chk("post_reset_level0", lv, 80'd0);
    frame_a({80{1'b1}}, lv, rs, fl);
    frame_a({80{1'b1}}, lv, rs, fl);
    chk("post_reset_ones", lv, {80{1'b1}});

    // Drop enable part-way through a frame; that frame must still complete.
    repeat (48) @(posedge clk);
    #1;
    enable = 1'b0;
    frame_a(80'd0, lv, rs, fl);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ctl", {busy, sh_ld_n, rclk}, 3'b010);
    act = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (rclk || !sh_ld_n || frame_done || busy) act++;
    end
    chk("idle_quiet", act, 0);

    // Small instance: no filtering, level follows every frame.
    prev_b = 8'd0;
    panel_b = 8'($urandom());
    enable_b = 1'b1;
    last_fd = 0;
    for (int f = 0; f < 10; f++) begin
      got_b = 1'b0;
      for (int i = 0; i < 100 && !got_b; i++) begin
        @(posedge clk); #1;
        if (frame_done_b) got_b = 1'b1;
      end
      chk("b_frame_seen", got_b, 1'b1);
      if (f > 0) chk("b_frame_len", cyc_cnt - last_fd, 18);
      last_fd = cyc_cnt;
      chk("b_level", level_b, panel_b);
      chk("b_rise", rise_b, panel_b & ~prev_b);
      chk("b_fall", fall_b, ~panel_b & prev_b);
      prev_b = panel_b;
      panel_b = 8'($urandom());
    end
    enable_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
